msrv32_csr_unit: RTL and testbench

Machine-mode CSR file and CSR execution unit of the MSRV32 core. It sits directly downstream of msrv32_reg_block_2 and consumes its registered CSR fields: csr_addr_reg_out, csr_op_reg_out, csr_wr_en_reg_out, rs1_reg_out, imm_reg_out and pc_reg_out.
- Performs CSR read-modify-write.
- Maintains 64-bit cycle and instret counters.
- Handles trap entry and mret state updates for the writeback and PC-mux stages.

---
 rtl/msrv32_csr_pkg.sv | 55 +++++
 rtl/msrv32_csr_counter64.sv | 29 ++
 rtl/msrv32_csr_unit.sv | 147 ++++++++++++++
 tb/tb_msrv32_csr_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_csr_pkg.sv
// Shared definitions for the MSRV32 machine-mode CSR unit: address map,
// operation encodings, mstatus field positions and read-modify-write helpers.
package msrv32_csr_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   typedef enum logic [1:0] {
      CSR_NOP = 2'b00,
      CSR_RW  = 2'b01,
      CSR_RS  = 2'b10,
      CSR_RC  = 2'b11
   } csr_op_e;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_HI = 12;
   localparam int MSTATUS_MPP_LO = 11;

   // Only machine mode exists, so MPP is hardwired to 2'b11.
   function automatic logic [31:0] mstatus_value(input logic mie, input logic mpie);
      logic [31:0] v;
      v = '0;
      v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      v[MSTATUS_MPIE] = mpie;
      v[MSTATUS_MIE]  = mie;
      return v;
   endfunction

   function automatic logic [31:0] csr_apply(input csr_op_e op,
                                             input logic [31:0] old_val,
                                             input logic [31:0] operand);
      logic [31:0] v;
      case (op)
         CSR_RW:  v = operand;
         CSR_RS:  v = old_val | operand;
         CSR_RC:  v = old_val & ~operand;
         default: v = old_val;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/msrv32_csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves;
// a half write replaces that cycle's increment and never carries across.
module msrv32_csr_counter64 (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic        inc_in,
   input  logic        wr_lo_in,
   input  logic        wr_hi_in,
   input  logic [31:0] wr_data_in,
   output logic [63:0] count_out
);

   logic [63:0] count;

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         count <= '0;
      end else if (wr_lo_in) begin
         count[31:0] <= wr_data_in;
      end else if (wr_hi_in) begin
         count[63:32] <= wr_data_in;
      end else if (inc_in) begin
         count <= count + 64'd1;
      end
   end

   assign count_out = count;

endmodule

// File: rtl/msrv32_csr_unit.sv
// Machine-mode CSR file and CSR execution unit: combinational old-value read,
// read-modify-write commit, cycle/instret counters, trap entry and mret.
module msrv32_csr_unit
   import msrv32_csr_pkg::*;
#(
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
   parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic [11:0] csr_addr_in,
   input  logic [2:0]  csr_op_in,
   input  logic        csr_wr_en_in,
   input  logic [31:0] rs1_in,
   input  logic [31:0] imm_in,
   input  logic [31:0] pc_in,
   input  logic        trap_taken_in,
   input  logic [31:0] mcause_in,
   input  logic        mret_in,
   input  logic        instret_inc_in,
   output logic [31:0] csr_data_out,
   output logic        illegal_csr_out,
   output logic [31:0] trap_address_out,
   output logic [31:0] epc_out,
   output logic        mie_out
);

   csr_op_e     op;
   logic [31:0] operand;
   logic [31:0] csr_rdata;
   logic [31:0] csr_wdata;
   logic        mapped;
   logic        read_only;
   logic        wr_attempt;
   logic        csr_active;
   logic        illegal;
   logic        csr_we;

   logic [29:0] mtvec_base;
   logic [29:0] mepc_word;
   logic [31:0] mscratch;
   logic [31:0] mcause;
   logic        mie;
   logic        mpie;
   logic [63:0] mcycle;
   logic [63:0] minstret;

   logic        unused_bits;

   assign unused_bits = ^{imm_in[31:5], pc_in[1:0]};

   assign op       = csr_op_e'(csr_op_in[1:0]);
   assign operand  = csr_op_in[2] ? {27'b0, imm_in[4:0]} : rs1_in;

   // Combinational read of the pre-write value; unmapped addresses read 0.
   always_comb begin
      mapped    = 1'b1;
      csr_rdata = '0;
      case (csr_addr_in)
         CSR_MSTATUS:                csr_rdata = mstatus_value(mie, mpie);
         CSR_MTVEC:                  csr_rdata = {mtvec_base, 2'b00};
         CSR_MSCRATCH:               csr_rdata = mscratch;
         CSR_MEPC:                   csr_rdata = {mepc_word, 2'b00};
         CSR_MCAUSE:                 csr_rdata = mcause;
         CSR_MCYCLE,   CSR_CYCLE:    csr_rdata = mcycle[31:0];
         CSR_MCYCLEH,  CSR_CYCLEH:   csr_rdata = mcycle[63:32];
         CSR_MINSTRET, CSR_INSTRET:  csr_rdata = minstret[31:0];
         CSR_MINSTRETH,CSR_INSTRETH: csr_rdata = minstret[63:32];
         CSR_MHARTID:                csr_rdata = HART_ID;
         default:                    mapped    = 1'b0;
      endcase
   end

   // RS/RC with a zero operand is a pure read, so it is legal on read-only CSRs.
   assign read_only  = (csr_addr_in[11:10] == 2'b11);
   assign wr_attempt = (op == CSR_RW) || ((op != CSR_NOP) && (operand != 32'd0));
   assign csr_active = csr_wr_en_in && (op != CSR_NOP);
   assign illegal    = csr_active && (!mapped || (read_only && wr_attempt));
   assign csr_we     = csr_active && !illegal && wr_attempt && !trap_taken_in;
   assign csr_wdata  = csr_apply(op, csr_rdata, operand);

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         mie  <= 1'b0;
         mpie <= 1'b0;
      end else if (trap_taken_in) begin
         mpie <= mie;
         mie  <= 1'b0;
      end else if (mret_in) begin
         mie  <= mpie;
         mpie <= 1'b1;
      end else if (csr_we && (csr_addr_in == CSR_MSTATUS)) begin
         mie  <= csr_wdata[MSTATUS_MIE];
         mpie <= csr_wdata[MSTATUS_MPIE];
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         mepc_word <= '0;
         mcause    <= '0;
      end else if (trap_taken_in) begin
         mepc_word <= pc_in[31:2];
         mcause    <= mcause_in;
      end else begin
         if (csr_we && (csr_addr_in == CSR_MEPC))   mepc_word <= csr_wdata[31:2];
         if (csr_we && (csr_addr_in == CSR_MCAUSE)) mcause    <= csr_wdata;
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         mtvec_base <= RESET_MTVEC[31:2];
         mscratch   <= '0;
      end else begin
         if (csr_we && (csr_addr_in == CSR_MTVEC))    mtvec_base <= csr_wdata[31:2];
         if (csr_we && (csr_addr_in == CSR_MSCRATCH)) mscratch   <= csr_wdata;
      end
   end

   msrv32_csr_counter64 u_mcycle (
      .clk_in     (clk_in),
      .reset_in   (reset_in),
      .inc_in     (1'b1),
      .wr_lo_in   (csr_we && (csr_addr_in == CSR_MCYCLE)),
      .wr_hi_in   (csr_we && (csr_addr_in == CSR_MCYCLEH)),
      .wr_data_in (csr_wdata),
      .count_out  (mcycle)
   );

   msrv32_csr_counter64 u_minstret (
      .clk_in     (clk_in),
      .reset_in   (reset_in),
      .inc_in     (instret_inc_in),
      .wr_lo_in   (csr_we && (csr_addr_in == CSR_MINSTRET)),
      .wr_hi_in   (csr_we && (csr_addr_in == CSR_MINSTRETH)),
      .wr_data_in (csr_wdata),
      .count_out  (minstret)
   );

   assign csr_data_out     = csr_rdata;
   assign illegal_csr_out  = illegal;
   assign trap_address_out = {mtvec_base, 2'b00};
   assign epc_out          = {mepc_word, 2'b00};
   assign mie_out          = mie;

endmodule

// File: tb/tb_msrv32_csr_unit.sv
// Scoreboard bench for msrv32_csr_unit: directed scenarios plus random traffic
// checked against a register-level behavioural model of the CSR file.
module tb_msrv32_csr_unit;

   logic        clk = 1'b0;
   logic        reset_in = 1'b1;
   logic [11:0] csr_addr_in = '0;
   logic [2:0]  csr_op_in = '0;
   logic        csr_wr_en_in = 1'b0;
   logic [31:0] rs1_in = '0;
   logic [31:0] imm_in = '0;
   logic [31:0] pc_in = '0;
   logic        trap_taken_in = 1'b0;
   logic [31:0] mcause_in = '0;
   logic        mret_in = 1'b0;
   logic        instret_inc_in = 1'b0;
   logic [31:0] csr_data_out;
   logic        illegal_csr_out;
   logic [31:0] trap_address_out;
   logic [31:0] epc_out;
   logic        mie_out;

   msrv32_csr_unit dut (
      .clk_in           (clk),
      .reset_in         (reset_in),
      .csr_addr_in      (csr_addr_in),
      .csr_op_in        (csr_op_in),
      .csr_wr_en_in     (csr_wr_en_in),
      .rs1_in           (rs1_in),
      .imm_in           (imm_in),
      .pc_in            (pc_in),
      .trap_taken_in    (trap_taken_in),
      .mcause_in        (mcause_in),
      .mret_in          (mret_in),
      .instret_inc_in   (instret_inc_in),
      .csr_data_out     (csr_data_out),
      .illegal_csr_out  (illegal_csr_out),
      .trap_address_out (trap_address_out),
      .epc_out          (epc_out),
      .mie_out          (mie_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic        ill;
      logic [31:0] tvec;
      logic [31:0] epc;
      logic        mie;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc_no   = 0;

   localparam logic [2:0] OP_RW  = 3'b001;
   localparam logic [2:0] OP_RS  = 3'b010;
   localparam logic [2:0] OP_RC  = 3'b011;
   localparam logic [2:0] OP_RSI = 3'b110;

   // Architectural model state
   logic        m_mie, m_mpie;
   logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
   logic [63:0] m_cycle, m_instret;

   function automatic void model_reset();
      m_mie = 0; m_mpie = 0;
      m_mtvec = 32'h0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
      m_cycle = 0; m_instret = 0;
   endfunction

   function automatic void model_read(input logic [11:0] a, output logic hit, output logic [31:0] v);
      hit = 1'b1;
      v   = 32'h0;
      case (a)
         12'h300: v = 32'h0000_1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
         12'h305: v = m_mtvec;
         12'h340: v = m_mscratch;
         12'h341: v = m_mepc;
         12'h342: v = m_mcause;
         12'hB00, 12'hC00: v = m_cycle[31:0];
         12'hB80, 12'hC80: v = m_cycle[63:32];
         12'hB02, 12'hC02: v = m_instret[31:0];
         12'hB82, 12'hC82: v = m_instret[63:32];
         12'hF14: v = 32'h0;
         default: hit = 1'b0;
      endcase
   endfunction

   // Advance the model over one clock edge; returns the pre-edge read value and illegal flag.
   function automatic void model_step(input logic rst, input logic en, input logic [11:0] a,
                                      input logic [2:0] opc, input logic [31:0] rs1, input logic [31:0] imm,
                                      input logic [31:0] pc, input logic trap, input logic [31:0] cause,
                                      input logic mret, input logic inc,
                                      output logic [31:0] old, output logic ill);
      logic        hit, attempt, we, o_mie, o_mpie;
      logic [31:0] opnd, nv;
      logic [63:0] nc, ni;
      model_read(a, hit, old);
      opnd    = opc[2] ? {27'b0, imm[4:0]} : rs1;
      attempt = (opc[1:0] == 2'b01) || (opc[1:0] != 2'b00 && opnd != 0);
      ill     = en && opc[1:0] != 2'b00 && (!hit || (a[11:10] == 2'b11 && attempt));
      if (rst) begin
         model_reset();
         return;
      end
      we = en && opc[1:0] != 2'b00 && !ill && attempt && !trap;
      case (opc[1:0])
         2'b01:   nv = opnd;
         2'b10:   nv = old | opnd;
         default: nv = old & ~opnd;
      endcase
      nc = m_cycle + 64'd1;
      ni = m_instret + (inc ? 64'd1 : 64'd0);
      o_mie = m_mie; o_mpie = m_mpie;
      if (trap) begin
         m_mepc = {pc[31:2], 2'b00}; m_mcause = cause; m_mpie = o_mie; m_mie = 0;
      end else if (mret) begin
         m_mie = o_mpie; m_mpie = 1;
      end
      if (we) begin
         case (a)
            12'h300: if (!mret) begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h305: m_mtvec    = nv & 32'hFFFF_FFFC;
            12'h340: m_mscratch = nv;
            12'h341: m_mepc     = nv & 32'hFFFF_FFFC;
            12'h342: m_mcause   = nv;
            12'hB00: nc = {m_cycle[63:32], nv};
            12'hB80: nc = {nv, m_cycle[31:0]};
            12'hB02: ni = {m_instret[63:32], nv};
            12'hB82: ni = {nv, m_instret[31:0]};
            default: ;
         endcase
      end
      m_cycle   = nc;
      m_instret = ni;
   endfunction

   task automatic cyc(input logic en, input logic [11:0] a, input logic [2:0] opc,
                      input logic [31:0] rs1, input logic [31:0] imm,
                      input logic trap = 0, input logic [31:0] pc = 0, input logic [31:0] cause = 0,
                      input logic mret = 0, input logic inc = 0, input logic rst = 0);
      exp_t e;
      @(posedge clk);
      #1;
      reset_in = rst; csr_wr_en_in = en; csr_addr_in = a; csr_op_in = opc;
      rs1_in = rs1; imm_in = imm; pc_in = pc; trap_taken_in = trap;
      mcause_in = cause; mret_in = mret; instret_inc_in = inc;
      cyc_no++;
      e.cyc = cyc_no; e.tvec = m_mtvec; e.epc = m_mepc; e.mie = m_mie;
      model_step(rst, en, a, opc, rs1, imm, pc, trap, cause, mret, inc, e.data, e.ill);
      sb.push_back(e);
   endtask

   task automatic rd(input logic [11:0] a);
      cyc(1'b1, a, OP_RSI, 32'h0, 32'h0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 12'h000, 3'b000, 32'h0, 32'h0);
   endtask

   function automatic void check(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, exp);
   endfunction

   // Monitor: the DUT's combinational outputs are valid every cycle once inputs settle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("csr_data", e.cyc, csr_data_out, e.data);
            check("illegal", e.cyc, 32'(illegal_csr_out), 32'(e.ill));
            check("trap_address", e.cyc, trap_address_out, e.tvec);
            check("epc", e.cyc, epc_out, e.epc);
            check("mie", e.cyc, 32'(mie_out), 32'(e.mie));
         end
      end
   end

   initial begin
      logic [11:0] addrs [16];
      int          drain;
      logic [31:0] r;
      addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80, 12'hB02,
                12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14, 12'h7C0, 12'h123};
      repeat (2) @(posedge clk);
      model_reset();

      // Reset and counter start
      idle(5);
      rd(12'hB00); rd(12'hB80); rd(12'h300);

      // Read-modify-write on mscratch
      cyc(1, 12'h340, OP_RW, 32'hDEAD_BEEF, 0);
      cyc(1, 12'h340, OP_RSI, 0, 32'h10);
      rd(12'h340);

      // Trap entry drops a concurrent write, then mret
      cyc(1, 12'h300, OP_RW, 32'h8, 0);
      cyc(1, 12'h340, OP_RW, 32'h1234_5678, 0, 1, 32'h0000_0203, 32'd11);
      rd(12'h341); rd(12'h342); rd(12'h300); rd(12'h340);
      cyc(1, 12'h300, OP_RW, 32'h0, 0, 0, 0, 0, 1);
      rd(12'h300);

      // mcycle wrap and shadow tracking
      cyc(1, 12'hB00, OP_RW, 32'hFFFF_FFFE, 0);
      cyc(1, 12'hB80, OP_RW, 32'hFFFF_FFFF, 0);
      rd(12'hB00); rd(12'hB80); rd(12'hC80); rd(12'hC00); rd(12'hB80);

      // Illegal accesses and a legal zero-operand read of a read-only counter
      cyc(1, 12'hC00, OP_RW, 32'h55, 0);
      cyc(1, 12'h7C0, OP_RW, 32'h55, 0);
      cyc(1, 12'hC00, OP_RS, 32'h0, 0);
      cyc(1, 12'hF14, OP_RC, 32'h1, 0);
      rd(12'hC00);

      // Mid-stream reset after nonzero state
      cyc(1, 12'h305, OP_RW, 32'h0000_1000, 0);
      cyc(1, 12'h342, OP_RW, 32'h7, 0, 0, 0, 0, 0, 1);
      cyc(1, 12'h300, OP_RS, 32'h88, 0, 0, 0, 0, 0, 1);
      cyc(0, 12'h000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1);
      rd(12'h305); rd(12'h340); rd(12'h341); rd(12'h342); rd(12'h300);
      rd(12'hB00); rd(12'hB02);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         r = $urandom;
         cyc(($urandom_range(0, 7) != 0), addrs[$urandom_range(0, 15)], 3'($urandom),
             (r[1:0] == 2'b00) ? 32'h0 : $urandom, (r[3:2] == 2'b00) ? 32'h0 : $urandom,
             ($urandom_range(0, 15) == 0), $urandom, $urandom,
             ($urandom_range(0, 15) == 0), r[4], ($urandom_range(0, 299) == 0));
      end
      idle(1);

      drain = 0;
      while (sb.size() > 0 && drain < 10) begin
         @(negedge clk);
         drain++;
      end
      #1;
      check("scoreboard_drained", cyc_no, 32'(sb.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
